// File: rtl/tuner_phy_ctrl_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tuner_phy_ctrl_arb: shares one tuner-code port and one power-detect port
// between CH_SEARCH and CH_LOCK. Optional macro: TUNER_PHY_ARB_RR_EN. Rev 1.0
// ----------------------------------------------------------------------------
module tuner_phy_ctrl_arb #(
  parameter int CODE_WIDTH     = 8,
  parameter int PWR_WIDTH      = 8,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              i_ch_req,
  input  logic [2*CODE_WIDTH-1:0] i_ch_code,
  output logic [1:0]              o_ch_gnt,
  output logic                    o_ch_done,
  output logic [PWR_WIDTH-1:0]    o_ch_pwr,
  output logic                    o_ch_err,
  output logic                    o_tune_valid,
  output logic [CODE_WIDTH-1:0]   o_tune_code,
  input  logic                    i_tune_ready,
  output logic                    o_det_req,
  input  logic                    i_det_valid,
  input  logic [PWR_WIDTH-1:0]    i_det_pwr,
  output logic [1:0]              o_arb_state
);

  typedef enum logic {CH_SEARCH = 1'b0, CH_LOCK = 1'b1} tuner_ctrl_ch_e;

  typedef enum logic [1:0] {
    ARB_CTRL_INIT = 2'd0,
    TUNE          = 2'd1,
    SYNC          = 2'd2,
    COMMIT        = 2'd3
  } tuner_phy_ctrl_arb_state_e;

  localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] c_settle_last  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one      = CNT_W'(1);

  tuner_phy_ctrl_arb_state_e r_state;
  logic [1:0]            r_gnt;
  logic                  r_done;
  logic [PWR_WIDTH-1:0]  r_pwr;
  logic                  r_err;
  logic                  r_tune_valid;
  logic [CODE_WIDTH-1:0] r_tune_code;
  logic                  r_det_req;
  logic [CNT_W-1:0]      r_cnt;
  logic [1:0]            w_pick;
  logic [CODE_WIDTH-1:0] w_code;

`ifdef TUNER_PHY_ARB_RR_EN
  tuner_ctrl_ch_e r_last;

  // On contention the channel that did not win last time goes next.
  always_comb begin
    w_pick = i_ch_req;
    if (i_ch_req == 2'b11) begin
      w_pick = (r_last == CH_LOCK) ? 2'b01 : 2'b10;
    end
  end
`else
  always_comb begin
    w_pick = i_ch_req[CH_LOCK] ? 2'b10 : {1'b0, i_ch_req[CH_SEARCH]};
  end
`endif

  assign w_code = w_pick[1] ? i_ch_code[CODE_WIDTH +: CODE_WIDTH]
                            : i_ch_code[0 +: CODE_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ARB_CTRL_INIT;
      r_gnt        <= 2'b00;
      r_done       <= 1'b0;
      r_pwr        <= '0;
      r_err        <= 1'b0;
      r_tune_valid <= 1'b0;
      r_tune_code  <= '0;
      r_det_req    <= 1'b0;
      r_cnt        <= '0;
`ifdef TUNER_PHY_ARB_RR_EN
      r_last       <= CH_SEARCH;
`endif
    end else begin
      case (r_state)
        ARB_CTRL_INIT: begin
          if (|w_pick) begin
            r_gnt        <= w_pick;
            r_tune_code  <= w_code;
            r_tune_valid <= 1'b1;
            r_cnt        <= '0;
            r_state      <= TUNE;
`ifdef TUNER_PHY_ARB_RR_EN
            r_last       <= w_pick[1] ? CH_LOCK : CH_SEARCH;
`endif
          end
        end
        TUNE: begin
          if (i_tune_ready) begin
            r_tune_valid <= 1'b0;
            r_cnt        <= '0;
            r_state      <= SYNC;
          end else if (r_cnt == c_timeout_last) begin
            r_tune_valid <= 1'b0;
            r_pwr        <= '0;
            r_err        <= 1'b1;
            r_done       <= 1'b1;
            r_state      <= COMMIT;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        SYNC: begin
          // Settle phase counts completed cycles; the counter is then reused for the detect timeout.
          if (!r_det_req) begin
            if (r_cnt == c_settle_last) begin
              r_det_req <= 1'b1;
              r_cnt     <= '0;
            end else begin
              r_cnt <= r_cnt + c_cnt_one;
            end
          end else if (i_det_valid) begin
            r_det_req <= 1'b0;
            r_pwr     <= i_det_pwr;
            r_err     <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= COMMIT;
          end else if (r_cnt == c_timeout_last) begin
            r_det_req <= 1'b0;
            r_pwr     <= '0;
            r_err     <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= COMMIT;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        COMMIT: begin
          r_gnt   <= 2'b00;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_cnt   <= '0;
          r_state <= ARB_CTRL_INIT;
        end
        default: r_state <= ARB_CTRL_INIT;
      endcase
    end
  end

  assign o_ch_gnt     = r_gnt;
  assign o_ch_done    = r_done;
  assign o_ch_pwr     = r_pwr;
  assign o_ch_err     = r_err;
  assign o_tune_valid = r_tune_valid;
  assign o_tune_code  = r_tune_code;
  assign o_det_req    = r_det_req;
  assign o_arb_state  = r_state;

endmodule
`default_nettype wire

// File: doc/tuner_phy_ctrl_arb.md
Name: tuner_phy_ctrl_arb

Overview:
- Arbitrates a single shared tuner-code (DAC) port and the power-detect port between two controller channels: CH_SEARCH (index 0) and CH_LOCK (index 1), per tuner_ctrl_ch_e.
- Each granted transaction runs ARB_CTRL_INIT -> TUNE -> SYNC -> COMMIT:
  - apply the requested code;
  - wait for settling, then take one power reading;
  - return the reading to the granted channel.
- Sits between the search/lock controllers and the tuner/detect PHY interfaces.

Parameters:
- CODE_WIDTH, 8, tuner code width.
- PWR_WIDTH, 8, power-detect reading width.
- SETTLE_CYCLES, 4, cycles waited in SYNC before det_req is raised (must be >= 1).
- TIMEOUT_CYCLES, 255, maximum cycles waiting on tune_ready or det_valid before aborting.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ch_req  in  2  per-channel request level, indexed by tuner_ctrl_ch_e
- ch_code  in  2*CODE_WIDTH  requested codes; channel i at [i*CODE_WIDTH +: CODE_WIDTH]
- ch_gnt  out  2  one-hot grant, held from grant through COMMIT
- ch_done  out  1  one-cycle pulse in COMMIT; qualifies ch_pwr and ch_err for the granted channel
- ch_pwr  out  PWR_WIDTH  latched power reading
- ch_err  out  1  transaction timed out (valid with ch_done)
- tune_valid  out  1  tuner code valid
- tune_code  out  CODE_WIDTH  code to apply
- tune_ready  in  1  tuner accepted code
- det_req  out  1  power-detect request
- det_valid  in  1  detect result valid
- det_pwr  in  PWR_WIDTH  detect result
- arb_state  out  2  current tuner_phy_ctrl_arb_state_e

Behaviour:
- Reset (async assert, sync deassert):
  - state = ARB_CTRL_INIT;
  - all outputs 0 (ch_gnt, ch_done, ch_pwr, ch_err, tune_valid, tune_code, det_req);
  - counters 0; RR pointer = CH_SEARCH.
  - Reset mid-transaction aborts it with no ch_done.
- INIT:
  - If any ch_req is set, pick a winner (default: CH_LOCK has fixed priority over CH_SEARCH).
  - Latch that channel's ch_code, set the ch_gnt bit, go to TUNE next cycle.
  - The request is consumed at grant. Keeping req asserted means another transaction after COMMIT.
- TUNE:
  - tune_valid = 1 with the latched code; tune_code holds stable.
  - On tune_ready: tune_valid drops, go to SYNC, clear counter.
- SYNC:
  - Counter increments each cycle.
  - When counter == SETTLE_CYCLES, assert det_req and hold it until det_valid.
  - det_valid while det_req = 0 is ignored.
  - On det_valid with det_req = 1: latch det_pwr into ch_pwr, drop det_req, go to COMMIT.
- COMMIT:
  - One cycle: ch_done = 1, ch_err per timeout.
  - Next cycle: ch_gnt = 0, ch_done = 0, state = INIT.
  - ch_pwr holds until the next COMMIT.
- Latency:
  - With tune_ready and det_valid both returned in the cycle they are requested, grant to ch_done = SETTLE_CYCLES + 2 cycles.
  - Back-to-back transactions are separated by one INIT cycle.
- Timeout:
  - A single counter runs while waiting on tune_ready (TUNE) and on det_valid (SYNC, det_req high).
  - Reaching TIMEOUT_CYCLES: drop tune_valid/det_req, go to COMMIT with ch_err = 1 and ch_pwr = 0.
- Ignored during a transaction:
  - ch_req changes, including the granted channel dropping req; the transaction always completes.
  - ch_code changes after grant.
- Outputs are registered; ch_gnt is never multi-hot.
- Without the optional feature, continuous CH_LOCK requests starve CH_SEARCH. This is intended: tracking has precedence.

Optional Feature:
- Macro TUNER_PHY_ARB_RR_EN.
  - Defined: round-robin arbitration in INIT. When both channels request, grant the channel != the last granted one. The pointer updates at every grant.
  - Undefined: fixed priority, CH_LOCK > CH_SEARCH. No pointer state.
- The single-requester case behaves identically in both builds.

Test Plan:
- Reset, then ch_req=01, ch_code[0]=8'h3C, tune_ready immediate, det_valid with det_pwr=8'hA5 one cycle after det_req -> ch_gnt=01, tune_code=3C, det_req rises 4 cycles after SYNC entry, ch_done with ch_pwr=A5, ch_err=0.
- ch_req=11 held for 4 transactions -> default build grants 10,10,10,10; with TUNER_PHY_ARB_RR_EN grants alternate (10,01,10,01).
- tune_ready held 0 -> ch_done after 255 wait cycles with ch_err=1, ch_pwr=0, tune_valid deasserted, state back to INIT.
- det_valid pulsed during the SYNC settle count (det_req=0) -> ignored; the later det_valid with det_pwr=8'h11 gives ch_pwr=11.
- Granted CH_SEARCH drops ch_req and changes ch_code mid-TUNE -> tune_code unchanged, transaction completes with ch_done.
- rst_n asserted in SYNC with det_req=1 -> all outputs 0 immediately (async), no ch_done; after release a new ch_req is granted normally.
